hockey_match_ctrl: RTL
======================

# hockey_match_ctrl

Match-level sequencer for the DigiHockey game. It sits above the puck/paddle core and runs a match from idle through serve, play, goal hold and game over. It keeps both scores, decides who serves next, gates the core, and declares the winner at WIN_SCORE goals.

## Interface
- WIN_SCORE, 3: goals needed to win; legal range 1..7.
- HOLD_CYCLES, 100: length of the post-goal freeze in clock cycles; must be ≥ 1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level input from the start button; the block detects its rising edge internally.
- goal_a  in  1  one-cycle pulse from the core: player A scored.
- goal_b  in  1  one-cycle pulse from the core: player B scored.
- core_en  out  1  high only in PLAY; the core advances the puck only while this is high.
- serve_a  out  1  high for exactly one cycle in SERVE when A serves.
- serve_b  out  1  high for exactly one cycle in SERVE when B serves.
- hold  out  1  high in GOAL_HOLD; the core freezes its LEDs.
- score_a  out  3  A's goals this match.
- score_b  out  3  B's goals this match.
- winner  out  2  00 = none, 01 = A, 10 = B; 11 never occurs.
- state  out  3  debug encoding: IDLE = 0, SERVE = 1, PLAY = 2, GOAL_HOLD = 3, GAME_OVER = 4.

## Operation
- Edge detect: start_q is registered every cycle. start_rise = start & ~start_q. start_q resets to 1, so a start held high through reset does not launch a match.
- IDLE:
  - On start_rise: clear both scores, set serve owner = A, clear winner, go to SERVE.
- SERVE:
  - Lasts exactly one cycle.
  - Assert serve_a or serve_b according to the serve owner.
  - Go to PLAY.
- PLAY:
  - core_en = 1.
  - goal_a alone: score_a += 1, serve owner = B (the conceding side serves), go to GOAL_HOLD.
  - goal_b alone: score_b += 1, serve owner = A, go to GOAL_HOLD.
  - goal_a and goal_b in the same cycle: treated as a core fault. Ignore both, no score change, stay in PLAY.
- GOAL_HOLD:
  - hold = 1. The hold counter loads 0 on entry and increments each cycle.
  - When the counter reaches HOLD_CYCLES-1:
    - If score_a == WIN_SCORE: winner = 01, go to GAME_OVER.
    - Else if score_b == WIN_SCORE: winner = 10, go to GAME_OVER.
    - Else go to SERVE.
- GAME_OVER:
  - Scores and winner hold their values.
  - On start_rise: clear scores and winner, set serve owner = A, go to SERVE.
- Ignored inputs:
  - goal_a and goal_b are ignored in every state except PLAY.
  - start_rise is ignored in every state except IDLE and GAME_OVER.
- Widths: scores are 3-bit and never exceed WIN_SCORE, because the win check precedes the next PLAY. The hold counter is wide enough for HOLD_CYCLES-1 and saturates nowhere.
- Outputs are Moore decodes of state, except the scores and winner registers.
- Unused state encodings (5..7) return to IDLE on the next clock.

## Timing
- Reset:
  - state = IDLE; core_en, serve_a, serve_b, hold = 0; scores = 0; winner = 00.
  - Serve owner = A; hold counter = 0; start_q = 1.
- Reset has priority over all transitions. Asserting rst in any state, including mid-hold, takes effect at the next rising edge, and every register returns to its reset value.
- Launch latency: start_rise sampled at edge k puts the block in SERVE in cycle k+1, with serve_x high. The block is in PLAY with core_en high in cycle k+2.
- Goal latency: a goal pulse sampled at edge k puts the block in GOAL_HOLD in cycle k+1, with the score already updated and core_en low.
- GOAL_HOLD lasts exactly HOLD_CYCLES cycles. After that the block is in SERVE for one cycle, then PLAY.
- core_en is never high in the same cycle as hold or serve_x.

## Test plan
(WIN_SCORE = 3, HOLD_CYCLES = 4.)
- Reset with start held: rst = 1 with start = 1 for 2 cycles, then release rst and keep start = 1 → state stays IDLE, all outputs 0.
- Launch: drop start, then raise it for 3 cycles → SERVE for one cycle with serve_a = 1, then PLAY with core_en = 1. Only one launch occurs.
- Goal and serve alternation: in PLAY, pulse goal_a → next cycle score_a = 1 and hold = 1 for exactly 4 cycles. Then SERVE with serve_b = 1, then PLAY.
- Simultaneous goals: in PLAY, pulse goal_a and goal_b together → scores unchanged, still PLAY. Also pulse goal_b during GOAL_HOLD → ignored.
- Win: B scores 3 times → after the third hold, state = GAME_OVER, winner = 10, score_b = 3, core_en = 0. A start_rise then → scores 0, winner 00, serve_a = 1.
- Reset mid-hold: assert rst during GOAL_HOLD cycle 2 → next cycle IDLE, scores 0, hold 0.

Source files
------------

// File: rtl/hockey_match_ctrl.sv
// Match-level sequencer for DigiHockey: runs idle -> serve -> play -> goal hold -> game over,
// keeps both scores, picks the next server and declares the winner at WIN_SCORE goals.
module hockey_match_ctrl #(
    parameter int WIN_SCORE   = 3,
    parameter int HOLD_CYCLES = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       goal_a,
    input  logic       goal_b,
    output logic       core_en,
    output logic       serve_a,
    output logic       serve_b,
    output logic       hold,
    output logic [2:0] score_a,
    output logic [2:0] score_b,
    output logic [1:0] winner,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SERVE     = 3'd1;
    localparam logic [2:0] S_PLAY      = 3'd2;
    localparam logic [2:0] S_GOAL_HOLD = 3'd3;
    localparam logic [2:0] S_GAME_OVER = 3'd4;

    localparam int             HCW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
    localparam logic [2:0]     WIN       = 3'(WIN_SCORE);

    logic [2:0]     state_q, state_d;
    logic           start_q, start_d;
    logic [2:0]     score_a_q, score_a_d;
    logic [2:0]     score_b_q, score_b_d;
    logic [1:0]     winner_q, winner_d;
    logic           serve_b_own_q, serve_b_own_d;   // 1 = B serves next
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           start_rise;

    assign start_rise = start & ~start_q;

    // NOTE: every *_d gets its hold value first so no path through the case leaves a latch.
    always_comb begin
        state_d       = state_q;
        start_d       = start;
        score_a_d     = score_a_q;
        score_b_d     = score_b_q;
        winner_d      = winner_q;
        serve_b_own_d = serve_b_own_q;
        hold_cnt_d    = hold_cnt_q;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_rise) begin
                    score_a_d     = 3'd0;
                    score_b_d     = 3'd0;
                    winner_d      = 2'b00;
                    serve_b_own_d = 1'b0;
                    state_d       = S_SERVE;
                end
            end
            S_SERVE: state_d = S_PLAY;
            S_PLAY: begin
                // Both pulses together is a core fault and is dropped.
                if (goal_a && !goal_b) begin
                    score_a_d     = score_a_q + 3'd1;
                    serve_b_own_d = 1'b1;
                    hold_cnt_d    = '0;
                    state_d       = S_GOAL_HOLD;
                end else if (goal_b && !goal_a) begin
                    score_b_d     = score_b_q + 3'd1;
                    serve_b_own_d = 1'b0;
                    hold_cnt_d    = '0;
                    state_d       = S_GOAL_HOLD;
                end
            end
            S_GOAL_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    if (score_a_q == WIN) begin
                        winner_d = 2'b01;
                        state_d  = S_GAME_OVER;
                    end else if (score_b_q == WIN) begin
                        winner_d = 2'b10;
                        state_d  = S_GAME_OVER;
                    end else begin
                        state_d = S_SERVE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use <= so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            start_q       <= 1'b1;
            score_a_q     <= 3'd0;
            score_b_q     <= 3'd0;
            winner_q      <= 2'b00;
            serve_b_own_q <= 1'b0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            score_a_q     <= score_a_d;
            score_b_q     <= score_b_d;
            winner_q      <= winner_d;
            serve_b_own_q <= serve_b_own_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign core_en = (state_q == S_PLAY);
    assign serve_a = (state_q == S_SERVE) && !serve_b_own_q;
    assign serve_b = (state_q == S_SERVE) && serve_b_own_q;
    assign hold    = (state_q == S_GOAL_HOLD);
    assign score_a = score_a_q;
    assign score_b = score_b_q;
    assign winner  = winner_q;
    assign state   = state_q;

endmodule
